// File: rtl/cmd_arb.sv
// -----------------------------------------------------------------------------
// cmd_arb
//   Round-robin arbiter and sequencer that shares one 3-byte command processor
//   between NREQ requesters. The winner's opcode and operands are latched at
//   grant, streamed to the processor as three back-to-back byte strobes, and
//   the processor's result is returned to the winner with a one-cycle done
//   pulse. Bad opcodes and processor timeouts finish with err=1, result=0.
//
// Parameters
//   NREQ     number of requesters (2..8)
//   TIMEOUT  maximum cycles spent waiting for the processor (4..255)
//
// Ports
//   clk          system clock, rising edge
//   res          asynchronous active-low reset
//   req          per-requester pending flag (level)
//   req_cmd      opcode of requester i in [8i+7:8i]
//   req_a        operand A, same packing
//   req_b        operand B, same packing
//   gnt          one-hot grant, SEND_CMD through DONE inclusive
//   done         one-cycle pulse to the owning requester
//   result       returned result, held until the next done
//   err          abort flag, valid with done
//   din_pro      byte to processor
//   en_din_pro   byte strobe to processor
//   dout_pro     processor result
//   en_dout_pro  processor result strobe (only honoured while waiting)
// -----------------------------------------------------------------------------
module cmd_arb #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              res,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] req_cmd,
  input  logic [8*NREQ-1:0] req_a,
  input  logic [8*NREQ-1:0] req_b,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic [7:0]        result,
  output logic              err,
  output logic [7:0]        din_pro,
  output logic              en_din_pro,
  input  logic [7:0]        dout_pro,
  input  logic              en_dout_pro
);

  localparam int         PW       = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND_CMD,
    S_SEND_A,
    S_SEND_B,
    S_WAIT,
    S_DONE
  } state_t;

  state_t        state, state_nx;
  logic [PW-1:0] ptr;       // round-robin start position
  logic [PW-1:0] owner;     // requester currently being served
  logic [PW-1:0] win_idx;
  logic          win_found;
  logic          win_ok;
  logic [7:0]    win_cmd, win_a, win_b;
  logic [7:0]    a_q, b_q;
  logic [7:0]    timer;

  // (base + off) modulo NREQ, for off in 0..NREQ
  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NREQ) sum = sum - NREQ;
    return PW'(sum);
  endfunction

  function automatic logic [NREQ-1:0] onehot(input logic [PW-1:0] idx);
    logic [NREQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // First pending requester at or after the pointer, wrapping around.
  always_comb begin : p_arb
    // NOTE: every variable written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    win_found = 1'b0;
    win_idx   = ptr;
    for (int i = 0; i < NREQ; i++) begin
      if (!win_found && req[wrap_inc(ptr, i)]) begin
        win_found = 1'b1;
        win_idx   = wrap_inc(ptr, i);
      end
    end
  end

  assign win_cmd = req_cmd[{win_idx, 3'b000} +: 8];
  assign win_a   = req_a[{win_idx, 3'b000} +: 8];
  assign win_b   = req_b[{win_idx, 3'b000} +: 8];
  assign win_ok  = (win_cmd >= 8'h0A) && (win_cmd <= 8'h0D);

  always_comb begin : p_next
    state_nx = state;
    case (state)
      S_IDLE:     if (win_found) state_nx = win_ok ? S_SEND_CMD : S_DONE;
      S_SEND_CMD: state_nx = S_SEND_A;
      S_SEND_A:   state_nx = S_SEND_B;
      S_SEND_B:   state_nx = S_WAIT;
      // A strobe in the final timer cycle still wins over the timeout.
      S_WAIT:     if (en_dout_pro || (timer == TMO_LAST)) state_nx = S_DONE;
      S_DONE:     state_nx = S_IDLE;
      default:    state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge res) begin : p_state
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!res) state <= S_IDLE;
    else      state <= state_nx;
  end

  // All outputs are registered: they are computed from the transition being
  // taken so they appear in the cycle the new state is entered.
  always_ff @(posedge clk or negedge res) begin : p_data
    if (!res) begin
      ptr        <= '0;
      owner      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      timer      <= '0;
      gnt        <= '0;
      done       <= '0;
      result     <= '0;
      err        <= 1'b0;
      din_pro    <= '0;
      en_din_pro <= 1'b0;
    end else begin
      done       <= '0;
      din_pro    <= '0;
      en_din_pro <= 1'b0;
      case (state)
        S_IDLE: begin
          if (win_found) begin
            owner <= win_idx;
            gnt   <= onehot(win_idx);
            a_q   <= win_a;
            b_q   <= win_b;
            if (win_ok) begin
              // The opcode goes out straight from the request bus.
              din_pro    <= win_cmd;
              en_din_pro <= 1'b1;
            end else begin
              done   <= onehot(win_idx);
              result <= 8'h00;
              err    <= 1'b1;
            end
          end
        end
        S_SEND_CMD: begin
          din_pro    <= a_q;
          en_din_pro <= 1'b1;
        end
        S_SEND_A: begin
          din_pro    <= b_q;
          en_din_pro <= 1'b1;
        end
        S_SEND_B: timer <= '0;
        S_WAIT: begin
          timer <= timer + 8'd1;
          if (state_nx == S_DONE) begin
            done   <= onehot(owner);
            result <= en_dout_pro ? dout_pro : 8'h00;
            err    <= !en_dout_pro;
          end
        end
        S_DONE: begin
          gnt <= '0;
          ptr <= wrap_inc(owner, 1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_arb.sv
// -----------------------------------------------------------------------------
// tb_cmd_arb
//   Self-checking bench for cmd_arb. A transaction-level model (round-robin
//   pick over the sampled request vector, per-transaction age counter, op
//   function) predicts gnt/done/result/err and the byte stream every cycle.
//   A behavioural processor collects the three bytes and answers after a
//   programmable delay. Directed scenarios come first, then random traffic.
// -----------------------------------------------------------------------------
module tb_cmd_arb;

  localparam int NREQ     = 4;
  localparam int TIMEOUT  = 64;
  localparam int WAIT_AGE = 3;   // transaction age of the first WAIT cycle

  logic              clk = 1'b0;
  logic              res;
  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] req_cmd, req_a, req_b;
  logic [NREQ-1:0]   gnt, done;
  logic [7:0]        result, din_pro, dout_pro;
  logic              err, en_din_pro, en_dout_pro;

  always #5 clk = ~clk;

  cmd_arb #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .res         (res),
    .req         (req),
    .req_cmd     (req_cmd),
    .req_a       (req_a),
    .req_b       (req_b),
    .gnt         (gnt),
    .done        (done),
    .result      (result),
    .err         (err),
    .din_pro     (din_pro),
    .en_din_pro  (en_din_pro),
    .dout_pro    (dout_pro),
    .en_dout_pro (en_dout_pro)
  );

  int n_checks = 0;
  int n_bad    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref_op(input logic [7:0] c, input logic [7:0] a, input logic [7:0] b);
    case (c)
      8'h0A:   return a + b;
      8'h0B:   return a - b;
      8'h0C:   return a & b;
      8'h0D:   return a ^ b;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [NREQ-1:0] bit_of(input int i);
    logic [NREQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
    for (int k = 0; k < NREQ; k++) begin
      int j = (p + k) % NREQ;
      if (r[j]) return j;
    end
    return -1;
  endfunction

  // Requesters
  bit         pend[NREQ];
  int         gap[NREQ];
  logic [7:0] r_cmd[NREQ], r_a[NREQ], r_b[NREQ];
  logic [NREQ-1:0] prev_req;
  logic [7:0] prev_cmd[NREQ], prev_a[NREQ], prev_b[NREQ];
  bit         random_mode;

  // Reference model state
  bit         m_busy, m_done_prev, m_bad;
  int         m_idx, m_age, m_strobe_age, m_ptr;
  logic [7:0] m_cmd, m_a, m_b, m_result;

  // Processor model
  logic [7:0] pbytes[3];
  int         pcnt, pcd, proc_delay;
  bit         proc_silent, inj_pend;

  // Observations
  bit              saw_done;
  logic [7:0]      last_result;
  logic            last_err;
  int              gnt_log[$];
  logic [NREQ-1:0] prev_gnt_obs;

  task automatic drive_inputs();
    for (int i = 0; i < NREQ; i++) begin
      req[i]           = pend[i];
      req_cmd[8*i +: 8] = r_cmd[i];
      req_a[8*i +: 8]   = r_a[i];
      req_b[8*i +: 8]   = r_b[i];
      prev_cmd[i]      = r_cmd[i];
      prev_a[i]        = r_a[i];
      prev_b[i]        = r_b[i];
    end
    prev_req = req;
  endtask

  // One clock: observe and check at the falling edge, then drive inputs.
  task automatic step();
    bit         exp_done_now, exp_en, stb;
    logic [7:0] exp_din;
    @(negedge clk);
    if (m_busy && m_done_prev) begin
      m_busy      = 1'b0;
      m_done_prev = 1'b0;
    end else if (m_busy) begin
      m_age++;
    end else if (prev_req != '0) begin
      m_idx        = rr_pick(prev_req, m_ptr);
      m_cmd        = prev_cmd[m_idx];
      m_a          = prev_a[m_idx];
      m_b          = prev_b[m_idx];
      m_bad        = !((m_cmd >= 8'h0A) && (m_cmd <= 8'h0D));
      m_busy       = 1'b1;
      m_age        = 0;
      m_strobe_age = -1;
    end
    exp_en  = m_busy && !m_bad && (m_age <= 2);
    exp_din = (m_age == 0) ? m_cmd : (m_age == 1) ? m_a : m_b;
    exp_done_now = m_busy && (m_bad ? (m_age == 0) :
                   (m_strobe_age >= 0) ? (m_age == m_strobe_age + 1) :
                                         (m_age == WAIT_AGE + TIMEOUT));
    check("gnt", 32'(gnt), 32'(m_busy ? bit_of(m_idx) : '0));
    check("en_din_pro", 32'(en_din_pro), 32'(exp_en));
    if (exp_en) check("din_pro", 32'(din_pro), 32'(exp_din));
    check("done", 32'(done), 32'(exp_done_now ? bit_of(m_idx) : '0));
    if (exp_done_now) begin
      m_result = (m_bad || m_strobe_age < 0) ? 8'h00 : ref_op(m_cmd, m_a, m_b);
      check("err", 32'(err), 32'(m_bad || m_strobe_age < 0));
      m_done_prev = 1'b1;
      m_ptr       = (m_idx + 1) % NREQ;
    end
    check("result", 32'(result), 32'(m_result));

    saw_done    = (done != '0);
    last_result = result;
    last_err    = err;
    if (gnt != '0 && prev_gnt_obs == '0)
      for (int k = 0; k < NREQ; k++) if (gnt[k]) gnt_log.push_back(k);
    prev_gnt_obs = gnt;

    // Processor: count down to the answer, collect bytes off the bus.
    stb = 1'b0;
    if (pcd > 0) begin
      pcd--;
      if (pcd == 0) stb = 1'b1;
    end
    if (en_din_pro === 1'b1) begin
      pbytes[pcnt] = din_pro;
      pcnt++;
      if (pcnt == 3) begin
        pcnt = 0;
        if (random_mode) begin
          proc_silent = ($urandom_range(0, 15) == 0);
          proc_delay  = ($urandom_range(0, 7) == 0) ? 64 : int'($urandom_range(1, 12));
        end
        if (!proc_silent) pcd = proc_delay;
      end
    end
    en_dout_pro = 1'b0;
    dout_pro    = 8'h00;
    if (stb) begin
      en_dout_pro = 1'b1;
      dout_pro    = ref_op(pbytes[0], pbytes[1], pbytes[2]);
    end else if (inj_pend && !m_busy) begin
      en_dout_pro = 1'b1;
      dout_pro    = 8'h99;
      inj_pend    = 1'b0;
    end
    if (en_dout_pro && m_busy && m_age >= WAIT_AGE && m_strobe_age < 0 && !exp_done_now)
      m_strobe_age = m_age;

    // Requesters drop in their done cycle; random ones re-arm after a gap.
    for (int i = 0; i < NREQ; i++) begin
      if (done[i] === 1'b1) begin
        pend[i] = 1'b0;
        gap[i]  = int'($urandom_range(0, 6));
      end else if (random_mode && !pend[i]) begin
        if (gap[i] > 0) gap[i]--;
        else begin
          pend[i]  = 1'b1;
          r_cmd[i] = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'($urandom_range(10, 13));
          r_a[i]   = 8'($urandom);
          r_b[i]   = 8'($urandom);
        end
      end
    end
    // Operands of the owner change after grant; the DUT must ignore that.
    if (random_mode && m_busy && !exp_done_now && $urandom_range(0, 3) == 0) begin
      r_cmd[m_idx] = 8'($urandom);
      r_a[m_idx]   = 8'($urandom);
      r_b[m_idx]   = 8'($urandom);
    end
    drive_inputs();
  endtask

  task automatic apply_reset(input string tag);
    res = 1'b0;
    #1;
    check({tag, "_gnt"},    32'(gnt), 0);
    check({tag, "_done"},   32'(done), 0);
    check({tag, "_result"}, 32'(result), 0);
    check({tag, "_err"},    32'(err), 0);
    check({tag, "_din"},    32'(din_pro), 0);
    check({tag, "_en_din"}, 32'(en_din_pro), 0);
    repeat (2) @(negedge clk);
    m_busy = 1'b0; m_done_prev = 1'b0; m_ptr = 0; m_result = 8'h00;
    pcnt = 0; pcd = 0; inj_pend = 1'b0;
    en_dout_pro = 1'b0; dout_pro = 8'h00;
    prev_gnt_obs = '0; saw_done = 1'b0;
    res = 1'b1;
    drive_inputs();
  endtask

  task automatic issue(input int i, input logic [7:0] c, input logic [7:0] a, input logic [7:0] b);
    pend[i]  = 1'b1;
    r_cmd[i] = c;
    r_a[i]   = a;
    r_b[i]   = b;
    drive_inputs();
  endtask

  task automatic run_until_done(input string tag, input int budget, output int n);
    n = 0;
    for (int k = 1; k <= budget; k++) begin
      step();
      if (saw_done) begin
        n = k;
        break;
      end
    end
    check({tag, "_done_in_budget"}, 32'(n != 0), 1);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int n;
    int exp_order[5] = '{0, 1, 2, 3, 0};
    bit drained;
    for (int i = 0; i < NREQ; i++) begin
      pend[i] = 1'b0; gap[i] = 0; r_cmd[i] = 8'h00; r_a[i] = 8'h00; r_b[i] = 8'h00;
    end
    random_mode = 1'b0; proc_silent = 1'b0; proc_delay = 3; inj_pend = 1'b0;
    m_busy = 1'b0; m_done_prev = 1'b0; m_idx = 0; m_age = 0; m_strobe_age = -1;
    m_ptr = 0; m_result = 8'h00; m_bad = 1'b0;
    pcnt = 0; pcd = 0; en_dout_pro = 1'b0; dout_pro = 8'h00;
    prev_gnt_obs = '0;
    res = 1'b1;
    drive_inputs();
    #2;
    apply_reset("reset");

    // Two plain transactions through requester 0.
    issue(0, 8'h0A, 8'h12, 8'h34);
    run_until_done("t1a", 20, n);
    check("t1a_result", 32'(last_result), 32'h46);
    check("t1a_err", 32'(last_err), 0);
    check("t1a_latency", 32'(n), 32'(proc_delay + 4));
    step();
    issue(0, 8'h0B, 8'h05, 8'h07);
    run_until_done("t1b", 20, n);
    check("t1b_result", 32'(last_result), 32'hFE);
    check("t1b_err", 32'(last_err), 0);
    step();

    // All four requesting from a fresh pointer, then requester 0 again.
    apply_reset("reset2");
    gnt_log.delete();
    for (int i = 0; i < NREQ; i++) begin
      pend[i]  = 1'b1;
      r_cmd[i] = 8'(8'h0A + i);
      r_a[i]   = 8'(16 * i + 1);
      r_b[i]   = 8'(i + 2);
    end
    drive_inputs();
    for (int k = 0; k < NREQ; k++) run_until_done("t2", 40, n);
    issue(0, 8'h0C, 8'hF0, 8'h3C);
    run_until_done("t2_again", 40, n);
    check("t2_count", 32'(gnt_log.size()), 5);
    for (int k = 0; k < 5 && k < gnt_log.size(); k++)
      check("t2_order", 32'(gnt_log[k]), 32'(exp_order[k]));
    step();

    // Unsupported opcode: no bus traffic, immediate error.
    issue(2, 8'h0F, 8'h01, 8'h02);
    run_until_done("t3", 5, n);
    check("t3_latency_le2", 32'(n >= 1 && n <= 2), 1);
    check("t3_err", 32'(last_err), 1);
    check("t3_result", 32'(last_result), 0);
    step();

    // Silent processor: timeout exactly TIMEOUT cycles after WAIT entry.
    proc_silent = 1'b1;
    issue(1, 8'h0C, 8'hAA, 8'h55);
    run_until_done("t4", 100, n);
    check("t4_wait_cycles", 32'(n - 4), 32'(TIMEOUT));
    check("t4_err", 32'(last_err), 1);
    check("t4_result", 32'(last_result), 0);
    proc_silent = 1'b0;
    step();

    // Reset during SEND_A, then the same request restarts from the opcode.
    proc_delay = 5;
    issue(1, 8'h0D, 8'h3C, 8'h0F);
    step();
    step();
    apply_reset("reset_mid");
    run_until_done("t5", 30, n);
    check("t5_restart_latency", 32'(n), 32'(proc_delay + 4));
    check("t5_result", 32'(last_result), 32'h33);
    check("t5_err", 32'(last_err), 0);
    step();
    inj_pend = 1'b1;
    repeat (3) step();
    check("t5_inj_fired", 32'(inj_pend), 0);
    check("t5_idle_strobe_ignored", 32'(result), 32'h33);

    // Strobe in the last WAIT cycle beats the timeout.
    proc_delay = TIMEOUT;
    issue(3, 8'h0A, 8'h80, 8'h90);
    run_until_done("t5_last", 100, n);
    check("t5_last_latency", 32'(n), 32'(WAIT_AGE + TIMEOUT + 1));
    check("t5_last_result", 32'(last_result), 32'h10);
    check("t5_last_err", 32'(last_err), 0);
    step();

    // Random traffic against the model, then drain.
    random_mode = 1'b1;
    repeat (3000) step();
    random_mode = 1'b0;
    drained = 1'b0;
    for (int k = 0; k < 600 && !drained; k++) begin
      step();
      drained = !m_busy;
      for (int i = 0; i < NREQ; i++) if (pend[i]) drained = 1'b0;
    end
    check("drain_idle", 32'(drained), 1);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
